// File: rtl/axi4lite_pkg.sv
// Response codes and FSM encodings shared by the AXI4-Lite interconnect and its slaves.
package axi4lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
endpackage

// File: rtl/axi4lite_csr_slave.sv
// AXI4-Lite CSR bank: B one cycle after the later of AW/W, R one cycle after AR.
// One outstanding transaction per direction; B/R held until bready/rready, new requests stalled meanwhile.
module axi4lite_csr_slave
    import axi4lite_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter int                  WIN_BITS   = 12,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic [2:0]                     s_awprot,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic [2:0]                     s_arprot,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] csr_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] csr_in,
    output logic [NUM_REGS-1:0]            csr_wr
);
    localparam int OFF_W  = WIN_BITS - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [0:0]            wstate_q, wstate_d;
    logic [0:0]            rstate_q, rstate_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [OFF_W-1:0]      awoff_q, awoff_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   csr_wr_q, csr_wr_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  aw_hs, w_hs;
    logic [OFF_W-1:0]      wr_off, ar_off;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [STRB_W-1:0]     wr_strb;
    logic                  unused_ok;

    assign s_awready = (wstate_q == W_IDLE) && !aw_held_q;
    assign s_wready  = (wstate_q == W_IDLE) && !w_held_q;
    assign s_arready = (rstate_q == R_IDLE);
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;

    // A held beat wins over the live bus so AW and W may arrive in any order.
    assign wr_off  = aw_held_q ? awoff_q : s_awaddr[WIN_BITS-1:2];
    assign wr_dat  = w_held_q ? wdata_q : s_wdata;
    assign wr_strb = w_held_q ? wstrb_q : s_wstrb;
    assign ar_off  = s_araddr[WIN_BITS-1:2];

    assign unused_ok = ^{s_awprot, s_arprot, s_awaddr[ADDR_WIDTH-1:WIN_BITS], s_awaddr[1:0],
                         s_araddr[ADDR_WIDTH-1:WIN_BITS], s_araddr[1:0]};

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awoff_d   = awoff_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        regs_d    = regs_q;
        csr_wr_d  = '0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (wstate_q == W_IDLE) begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awoff_d   = s_awaddr[WIN_BITS-1:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = s_wdata;
                wstrb_d  = s_wstrb;
            end
            if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                bresp_d = RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_off == OFF_W'(i) && !RO_MASK[i]) begin
                        bresp_d     = RESP_OKAY;
                        csr_wr_d[i] = 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wr_strb[b]) regs_d[i][b*8 +: 8] = wr_dat[b*8 +: 8];
                        end
                    end
                end
                bvalid_d  = 1'b1;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                wstate_d  = W_RESP;
            end
        end else if (s_bready) begin
            bvalid_d = 1'b0;
            wstate_d = W_IDLE;
        end
    end

    // Reads sample regs_q, so a read captured alongside a commit sees the old value.
    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rstate_q == R_IDLE) begin
            if (s_arvalid) begin
                rvalid_d = 1'b1;
                rstate_d = R_DATA;
                rresp_d  = RESP_SLVERR;
                rdata_d  = '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (ar_off == OFF_W'(i)) begin
                        rresp_d = RESP_OKAY;
                        rdata_d = RO_MASK[i] ? csr_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
                    end
                end
            end
        end else if (s_rready) begin
            rvalid_d = 1'b0;
            rstate_d = R_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awoff_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            csr_wr_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awoff_q   <= awoff_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            regs_q    <= regs_d;
            csr_wr_q  <= csr_wr_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) csr_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    assign csr_wr   = csr_wr_q;
    assign s_bvalid = bvalid_q;
    assign s_bresp  = bresp_q;
    assign s_rvalid = rvalid_q;
    assign s_rresp  = rresp_q;
    assign s_rdata  = rdata_q;
endmodule
